// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel engine: runs the engine, routes its writes into the
// output memory, then streams the finished frame back out over valid/ready.
module sobel_frame_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DIM_WIDTH  = 9,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  run_i,
   input  logic [DIM_WIDTH-1:0]  rows_i,
   input  logic [DIM_WIDTH-1:0]  cols_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic                  eng_start_o,
   input  logic                  eng_finish_i,
   input  logic                  eng_wr_en_i,
   input  logic [ADDR_WIDTH-1:0] eng_addr_i,
   output logic                  mem_wr_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  dout_valid_o,
   input  logic                  dout_ready_i,
   output logic [DATA_WIDTH-1:0] dout_data_o,
   output logic                  dout_last_o
);

   localparam int unsigned NW    = 2 * DIM_WIDTH;
   localparam int unsigned DEPTH = RD_LATENCY + 1;
   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned SW    = $clog2(DEPTH + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_READ  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [NW-1:0]         n_q, n_d;
   logic [NW-1:0]         rd_addr_q, rd_addr_d;
   logic [NW-1:0]         beat_q, beat_d;
   logic                  drain_q, drain_d;
   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]         cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  eng_start_q, eng_start_d;

   logic [NW-1:0]         n_calc;
   logic                  accept;
   logic                  fifo_valid;
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic                  last_beat;
   logic                  last_hs;
   logic                  stray;
   logic [SW-1:0]         inflight;
   logic [SW-1:0]         occ;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign n_calc     = NW'(rows_i) * NW'(cols_i);
   assign accept     = (state_q == ST_IDLE) && run_i;
   assign fifo_valid = (cnt_q != '0);
   assign pop        = fifo_valid && dout_ready_i;
   assign push       = pipe_q[RD_LATENCY-1];
   assign last_beat  = fifo_valid && (beat_q == n_q - NW'(1));
   assign last_hs    = last_beat && dout_ready_i;

   // Reads still travelling through the memory pipeline.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + SW'(pipe_q[i]);
      end
   end

   // Occupancy net of this cycle's pop keeps the read stream bubble-free.
   assign occ   = cnt_q - SW'(pop);
   assign issue = (state_q == ST_READ) && ((occ + inflight) < SW'(DEPTH)) && (rd_addr_q < n_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (run_i && (n_calc != '0)) state_d = ST_RUN;
         ST_RUN:   if (eng_finish_i) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_q) state_d = ST_READ;
         ST_READ:  if (last_hs) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_wr_en_o = 1'b0;
      mem_addr_o  = '0;
      stray       = 1'b0;
      done_d      = 1'b0;
      eng_start_d = (state_d == ST_RUN);
      busy_d      = (state_d != ST_IDLE);
      error_d     = error_q;
      unique case (state_q)
         ST_IDLE: begin
            stray = eng_wr_en_i;
            if (run_i && (n_calc == '0)) done_d = 1'b1;
         end
         ST_RUN, ST_DRAIN: begin
            mem_wr_en_o = eng_wr_en_i;
            mem_addr_o  = eng_addr_i;
         end
         ST_READ: begin
            mem_addr_o = ADDR_WIDTH'(rd_addr_q);
            stray      = eng_wr_en_i;
            done_d     = last_hs;
         end
         default: ;
      endcase
      if (accept) error_d = 1'b0;
      if (stray) error_d = 1'b1;
   end

   // Frame size, read/beat counters, read pipeline and return FIFO.
   always_comb begin
      n_d       = n_q;
      rd_addr_d = rd_addr_q;
      beat_d    = beat_q;
      drain_d   = (state_q == ST_DRAIN);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      fifo_d    = fifo_q;
      pipe_d    = '0;
      pipe_d[0] = issue;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      if (accept) begin
         n_d       = n_calc;
         rd_addr_d = '0;
         beat_d    = '0;
      end
      if (issue) rd_addr_d = rd_addr_q + NW'(1);
      if (push) begin
         fifo_d[wr_ptr_q] = mem_rdata_i;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         beat_d   = beat_q + NW'(1);
      end
      cnt_d = cnt_q + SW'(push) - SW'(pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_q         <= '0;
         rd_addr_q   <= '0;
         beat_q      <= '0;
         drain_q     <= 1'b0;
         pipe_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         eng_start_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         n_q         <= n_d;
         rd_addr_q   <= rd_addr_d;
         beat_q      <= beat_d;
         drain_q     <= drain_d;
         pipe_q      <= pipe_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         eng_start_q <= eng_start_d;
         fifo_q      <= fifo_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign eng_start_o  = eng_start_q;
   assign dout_valid_o = fifo_valid;
   assign dout_data_o  = fifo_q[rd_ptr_q];
   assign dout_last_o  = last_beat;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: two instances (read latency 1 and 2) share the engine
// stimulus; each has its own memory model and is scored against an expected-beat queue.
module tb_sobel_frame_ctrl;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [8:0]  rows;
   logic [8:0]  cols;
   logic        finish;
   logic        eng_wr;
   logic [15:0] eng_addr;
   logic [7:0]  eng_wdata;
   logic        ready;

   logic [1:0]  busy, done, err, start, mwr, vld, last;
   logic [15:0] maddr0, maddr1;
   logic [7:0]  rdata0, rdata1, rq1;
   logic [7:0]  dout0, dout1;

   logic [7:0]  mem0 [65536];
   logic [7:0]  mem1 [65536];

   beat_t q0[$];
   beat_t q1[$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sobel_frame_ctrl #(.RD_LATENCY(1)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .run_i(run), .rows_i(rows), .cols_i(cols),
      .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0]), .eng_start_o(start[0]),
      .eng_finish_i(finish), .eng_wr_en_i(eng_wr), .eng_addr_i(eng_addr),
      .mem_wr_en_o(mwr[0]), .mem_addr_o(maddr0), .mem_rdata_i(rdata0),
      .dout_valid_o(vld[0]), .dout_ready_i(ready), .dout_data_o(dout0), .dout_last_o(last[0])
   );

   sobel_frame_ctrl #(.RD_LATENCY(2)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .run_i(run), .rows_i(rows), .cols_i(cols),
      .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1]), .eng_start_o(start[1]),
      .eng_finish_i(finish), .eng_wr_en_i(eng_wr), .eng_addr_i(eng_addr),
      .mem_wr_en_o(mwr[1]), .mem_addr_o(maddr1), .mem_rdata_i(rdata1),
      .dout_valid_o(vld[1]), .dout_ready_i(ready), .dout_data_o(dout1), .dout_last_o(last[1])
   );

   // Output memories: one-cycle and two-cycle synchronous read.
   always @(posedge clk) begin
      if (mwr[0]) mem0[maddr0] <= eng_wdata;
      rdata0 <= mem0[maddr0];
   end

   always @(posedge clk) begin
      if (mwr[1]) mem1[maddr1] <= eng_wdata;
      rq1    <= mem1[maddr1];
      rdata1 <= rq1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outs();
      for (int d = 0; d < 2; d++) begin
         chk("reset_ctrl", 32'({busy[d], done[d], err[d], start[d], mwr[d], vld[d], last[d]}), 32'h0);
         chk("reset_addr", 32'(d ? maddr1 : maddr0), 32'h0);
         chk("reset_data", 32'(d ? dout1 : dout0), 32'h0);
      end
   endtask

   // Runs one frame from a negedge; returns at a negedge.
   task automatic run_frame(input int r, input int c, input logic [7:0] seed, input bit coincide,
                            input int pct, input int stray_at, input int abort_at, input bit midrun);
      int          n;
      bit   [1:0]  fin, pend, stall;
      logic [7:0]  sd [2];
      logic        sl [2];
      int          dcnt [2];
      int          first_i [2];
      int          last_i [2];
      bit          aborted;
      beat_t       e;
      logic [7:0]  od;
      n = r * c;
      fin = '0; pend = '0; stall = '0; aborted = 1'b0;
      for (int d = 0; d < 2; d++) begin
         dcnt[d] = 0; first_i[d] = 0; last_i[d] = 0; sd[d] = '0; sl[d] = 1'b0;
      end

      run = 1'b1; rows = 9'(r); cols = 9'(c);
      @(negedge clk);
      run = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("start_after_run", 32'(start[d]), 32'h1);
         chk("busy_after_run", 32'(busy[d]), 32'h1);
      end

      for (int a = 0; a < n; a++) begin
         eng_wr = 1'b1; eng_addr = 16'(a); eng_wdata = 8'(a) ^ seed;
         finish = coincide && (a == n - 1);
         if (midrun && a == 1) begin
            run = 1'b1; rows = 9'd3; cols = 9'd3;
         end else begin
            run = 1'b0;
         end
         @(negedge clk);
      end
      run = 1'b0;
      if (!coincide) begin
         eng_wr = 1'b0; finish = 1'b1;
         @(negedge clk);
      end
      eng_wr = 1'b0; finish = 1'b0;
      for (int a = 0; a < n; a++) begin
         e.data = 8'(a) ^ seed;
         e.last = (a == n - 1);
         q0.push_back(e);
         q1.push_back(e);
      end

      for (int i = 1; i <= 400 && fin != 2'b11; i++) begin
         if (i == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_outs();
            @(negedge clk);
            rst_n = 1'b1;
            q0.delete();
            q1.delete();
            aborted = 1'b1;
            break;
         end
         ready = ($urandom_range(99) < pct);
         if (i == stray_at) begin
            eng_wr = 1'b1; eng_addr = 16'd40; eng_wdata = 8'hEE;
         end else begin
            eng_wr = 1'b0;
         end
         if (i == 3) begin
            chk("first_rd_addr0", 32'(maddr0), 32'h0);
            chk("first_rd_addr1", 32'(maddr1), 32'h0);
         end
         for (int d = 0; d < 2; d++) begin
            od = d ? dout1 : dout0;
            dcnt[d] += int'(done[d]);
            if (pend[d]) begin
               chk("done_after_last", 32'(done[d]), 32'h1);
               chk("busy_after_last", 32'(busy[d]), 32'h0);
               pend[d] = 1'b0;
               fin[d] = 1'b1;
            end
            if (stall[d]) chk("stall_hold", 32'({vld[d], last[d], od}), 32'({1'b1, sl[d], sd[d]}));
            if (vld[d] && first_i[d] == 0) begin
               first_i[d] = i;
               chk("first_valid_cycle", 32'(i), 32'(d + 5));
            end
            stall[d] = vld[d] && !ready;
            sd[d] = od;
            sl[d] = last[d];
            if (vld[d] && ready) begin
               if ((d ? q1.size() : q0.size()) == 0) begin
                  chk("extra_beat", 32'(od), 32'hFFFF);
               end else begin
                  e = d ? q1.pop_front() : q0.pop_front();
                  chk("beat_data", 32'(od), 32'(e.data));
                  chk("beat_last", 32'(last[d]), 32'(e.last));
               end
               if (last[d]) begin
                  pend[d] = 1'b1;
                  last_i[d] = i;
               end
            end
         end
         @(negedge clk);
      end
      eng_wr = 1'b0;
      if (aborted) return;

      chk("stream_complete", 32'(fin), 32'h3);
      chk("queue0_empty", 32'(q0.size()), 32'h0);
      chk("queue1_empty", 32'(q1.size()), 32'h0);
      for (int d = 0; d < 2; d++) begin
         chk("done_pulses", 32'(dcnt[d]), 32'h1);
         chk("done_low_after", 32'(done[d]), 32'h0);
         chk("busy_low_after", 32'(busy[d]), 32'h0);
         if (pct == 100) chk("burst_no_bubble", 32'(last_i[d]), 32'(d + 5 + n - 1));
         chk("error_flag", 32'(err[d]), 32'(stray_at > 0));
      end
      if (stray_at > 0) begin
         chk("mem0_untouched", 32'(mem0[40]), 32'(8'd40 ^ seed));
         chk("mem1_untouched", 32'(mem1[40]), 32'(8'd40 ^ seed));
      end
      q0.delete();
      q1.delete();
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; rows = '0; cols = '0; finish = 1'b0;
      eng_wr = 1'b0; eng_addr = '0; eng_wdata = '0; ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outs();
      rst_n = 1'b1;
      @(negedge clk);

      // 4x4, writes then separate finish, ready held high
      run_frame(4, 4, 8'h5A, 1'b0, 100, 0, 0, 1'b0);

      // 8x6, final write coincident with finish, random ready, stray write in READ
      run_frame(8, 6, 8'h33, 1'b1, 50, 6, 0, 1'b0);

      // zero-size frame: immediate done, engine untouched, error cleared
      run = 1'b1; rows = 9'd0; cols = 9'd5;
      @(negedge clk);
      run = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("zero_done", 32'(done[d]), 32'h1);
         chk("zero_start", 32'(start[d]), 32'h0);
         chk("zero_busy", 32'(busy[d]), 32'h0);
         chk("zero_err_clr", 32'(err[d]), 32'h0);
         chk("zero_valid", 32'(vld[d]), 32'h0);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("zero_done_once", 32'(done[d]), 32'h0);
         chk("zero_start_late", 32'(start[d]), 32'h0);
      end

      // reset pulse mid-READ aborts the frame without a done pulse
      run_frame(4, 4, 8'hC3, 1'b1, 100, 0, 6, 1'b0);
      repeat (2) begin
         for (int d = 0; d < 2; d++) begin
            chk("abort_no_done", 32'(done[d]), 32'h0);
            chk("abort_idle", 32'(busy[d]), 32'h0);
         end
         @(negedge clk);
      end

      // 2x2 after the abort, with a run request mid-run that must be ignored
      run_frame(2, 2, 8'h96, 1'b0, 100, 0, 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Synthesizable frame sequencer for the Sobel engine: starts `sobel_exc`, routes its pixel writes into the output memory, waits for `finish_o`, then reads the whole frame back out of the output memory as a valid/ready pixel stream. It sits between `sobel_exc`, `output_memory` and a downstream sink such as a DMA or UART. It works with runtime frame sizes and any output-memory read latency from 1 to 2 cycles.

## Interface

Parameters:
- `DATA_WIDTH`, 8: pixel width.
- `ADDR_WIDTH`, 16: output-memory address width.
- `DIM_WIDTH`, 9: width of the row and column counts.
- `RD_LATENCY`, 1: output-memory read latency in cycles; legal values are 1 and 2.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `run_i` in 1: start a frame; sampled only in IDLE.
- `rows_i` in DIM_WIDTH: row count, latched when `run_i` is accepted.
- `cols_i` in DIM_WIDTH: column count, latched when `run_i` is accepted.
- `busy_o` out 1: high whenever the state is not IDLE.
- `done_o` out 1: one-cycle pulse at the end of a frame.
- `error_o` out 1: sticky stray-write flag; cleared when the next `run_i` is accepted.
- `eng_start_o` out 1: drives the engine `start_i`.
- `eng_finish_i` in 1: engine `finish_o`.
- `eng_wr_en_i` in 1: engine write enable.
- `eng_addr_i` in ADDR_WIDTH: engine write address.
- `mem_wr_en_o` out 1: output-memory write enable.
- `mem_addr_o` out ADDR_WIDTH: output-memory address.
- `mem_rdata_i` in DATA_WIDTH: output-memory read data.
- `dout_valid_o` out 1: stream valid.
- `dout_ready_i` in 1: stream ready.
- `dout_data_o` out DATA_WIDTH: stream pixel.
- `dout_last_o` out 1: marks the final pixel of the frame.

## Operation

- **States:** IDLE, RUN, DRAIN, READ.
- **IDLE.** When `run_i`=1:
  - Latch `rows_i` and `cols_i`, and compute `N = rows*cols` (width `2*DIM_WIDTH`; only the low `ADDR_WIDTH` bits drive addresses).
  - Clear `error_o`.
  - If N=0, pulse `done_o` next cycle and stay in IDLE. Otherwise go to RUN.
- **RUN:**
  - `eng_start_o`=1, held as a level.
  - `mem_wr_en_o` = `eng_wr_en_i` and `mem_addr_o` = `eng_addr_i`, combinational pass-through.
  - `eng_finish_i` sampled high → DRAIN.
- **DRAIN:**
  - `eng_start_o`=0; the pass-through stays active.
  - Lasts exactly 2 cycles so that a final write issued alongside `finish_o` lands in memory. Then go to READ.
- **READ:**
  - `mem_wr_en_o`=0. `mem_addr_o` = read counter `rd_addr`, starting at 0.
  - A read is issued when (FIFO occupancy + reads in flight) < RD_LATENCY+1 and `rd_addr` < N. Each issued read increments `rd_addr`.
  - Returned data enters a FIFO of depth RD_LATENCY+1. The FIFO head drives `dout_data_o`.
  - `dout_last_o` = `dout_valid_o` AND (beat counter == N-1).
  - On the handshake of the last beat: go to IDLE and pulse `done_o` in the following cycle.
- **Stray writes:** `eng_wr_en_i`=1 in IDLE or READ sets `error_o`, and the write is not forwarded.
- **Busy:** `run_i` in any state other than IDLE is ignored.

## Timing

- **Reset values:** every output is 0, the state is IDLE, and all counters and the FIFO are empty. Reset asserted mid-frame aborts immediately, with no `done_o` pulse.
- **Start latency:** `run_i` accepted at edge k → `eng_start_o`=1 and `busy_o`=1 from cycle k+1.
- **Finish to read:** finish sampled at edge f → the first read address is presented in cycle f+3. The first `dout_valid_o` appears in cycle f+3+RD_LATENCY+1.
- **Throughput:** with `dout_ready_i` held at 1, one beat per cycle and no bubbles.
- **Stream rules:** while `dout_valid_o`=1 and `dout_ready_i`=0, `dout_data_o` and `dout_last_o` stay stable and `dout_valid_o` does not drop. Backpressure never loses or duplicates a pixel.
- **Completion:** `done_o` is high in the cycle after the last handshake. `busy_o` falls in that same cycle.

## Test plan

1. **4×4 frame, ready=1.** The model engine writes `addr^8'h5A` to addresses 0..15, then finishes → exactly 16 beats in address order, `dout_last_o` only on beat 16, one `done_o` pulse, and `busy_o` low afterwards.
2. **8×6 frame, random ready (~50%).** → 48 beats in order with no loss or duplication, and valid/data stable during every stall. Repeat with RD_LATENCY=2.
3. **Final write coincident with `finish_o` at address N-1** → that value appears on the last beat.
4. **rows_i=0, cols_i=5** → `done_o` one cycle after `run_i`, `eng_start_o` never asserted, no beats.
5. **Engine write pulse during READ** → `error_o`=1, memory contents unchanged, and the stream still completes. The next `run_i` clears `error_o`.
6. **`rst_ni` low for 1 cycle mid-READ** → all outputs 0 immediately. A subsequent 2×2 run completes correctly, and a `run_i` issued mid-run is ignored.
